// File: rtl/exception_sequencer.sv
// ---------------------------------------------------------------------------
// exception_sequencer
//
// Multicycle exception sequencer that runs beside the main control unit of
// the 64-bit RISC-V datapath. On an invalid-opcode or arithmetic-overflow
// flag it stalls the control unit, saves the faulting PC into EPC, steers the
// exception address mux to the matching data-memory vector slot, and loads
// the handler address read from that slot into PC.
//
// Sequence: IDLE -> SAVE (1 cycle) -> ADDR (MEM_LAT cycles) -> LOAD (1 cycle)
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous, active-low reset
//   exc_opcode       invalid-opcode flag (level, sampled only in IDLE)
//   exc_ovf          ALU overflow flag (level, sampled only in IDLE)
//   pc_in            current PC value (already advanced by 4)
//   mem_data         data-memory read data
//   busy             sequence active; control unit freezes its FSM and enables
//   epc_write        EPC load enable (SAVE)
//   epc_out          faulting PC for EPC (SAVE only, else 0)
//   sel_mux_excecao  exception address mux select: 0 AluOut, 1 opcode vec, 2 ovf vec
//   pc_write         PC load enable (LOAD)
//   pc_next          handler address, zero-extended mem_data[7:0] (LOAD only, else 0)
//   done             one-cycle pulse on the handler load cycle
//   cause            sticky last cause: 0 none, 1 opcode, 2 overflow
//   drop_cnt         saturating count of flag edges ignored while busy
// ---------------------------------------------------------------------------
module exception_sequencer #(
   parameter int          DATA_W     = 64,
   parameter logic [7:0]  VEC_OPCODE = 8'd254,
   parameter logic [7:0]  VEC_OVF    = 8'd255,
   parameter int          MEM_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exc_opcode,
   input  logic              exc_ovf,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] mem_data,
   output logic              busy,
   output logic              epc_write,
   output logic [DATA_W-1:0] epc_out,
   output logic [2:0]        sel_mux_excecao,
   output logic              pc_write,
   output logic [DATA_W-1:0] pc_next,
   output logic              done,
   output logic [1:0]        cause,
   output logic [7:0]        drop_cnt
);

   typedef enum logic [1:0] {IDLE, SAVE, ADDR, LOAD} state_t;

   localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

   state_t            state;
   logic [2:0]        lat_cnt;
   logic [DATA_W-1:0] pc_cap;
   logic [1:0]        vsel;
   logic              exc_any;

   assign exc_any = exc_opcode | exc_ovf;

   // The vector addresses live in the external address mux; only the select
   // code leaves this block. Upper read-data bits are discarded by design.
   logic unused_bits;
   assign unused_bits = ^{VEC_OPCODE, VEC_OVF, mem_data[DATA_W-1:8]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         lat_cnt         <= '0;
         pc_cap          <= '0;
         vsel            <= '0;
         busy            <= 1'b0;
         epc_write       <= 1'b0;
         sel_mux_excecao <= '0;
         pc_write        <= 1'b0;
         done            <= 1'b0;
         cause           <= '0;
         drop_cnt        <= '0;
      end else begin
         // Flags seen while a sequence is running are not queued, only counted.
         if (state != IDLE && exc_any && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;

         // Control outputs are registered from the next state so they are
         // clean Moore outputs of the state register.
         case (state)
            IDLE: begin
               if (exc_any) begin
                  pc_cap    <= pc_in;
                  vsel      <= exc_opcode ? 2'd1 : 2'd2;  // opcode wins ties
                  cause     <= exc_opcode ? 2'd1 : 2'd2;
                  state     <= SAVE;
                  busy      <= 1'b1;
                  epc_write <= 1'b1;
               end
            end
            SAVE: begin
               lat_cnt         <= LAT_INIT;
               state           <= ADDR;
               epc_write       <= 1'b0;
               sel_mux_excecao <= {1'b0, vsel};
            end
            ADDR: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  state    <= LOAD;
                  pc_write <= 1'b1;
                  done     <= 1'b1;
               end
            end
            LOAD: begin
               state           <= IDLE;
               busy            <= 1'b0;
               pc_write        <= 1'b0;
               done            <= 1'b0;
               sel_mux_excecao <= '0;
            end
            default: begin
               state           <= IDLE;
               busy            <= 1'b0;
               epc_write       <= 1'b0;
               pc_write        <= 1'b0;
               done            <= 1'b0;
               sel_mux_excecao <= '0;
            end
         endcase
      end
   end

   // Data outputs decode from the state register: the faulting PC is the
   // captured (already advanced) PC minus 4, wrapping modulo 2^DATA_W; the
   // handler address uses the read data present during LOAD.
   assign epc_out = (state == SAVE) ? (pc_cap - DATA_W'(4)) : '0;
   assign pc_next = (state == LOAD) ? {{(DATA_W-8){1'b0}}, mem_data[7:0]} : '0;

endmodule

// File: tb/tb_exception_sequencer.sv
module tb_exception_sequencer;

   typedef struct packed {
      logic [63:0] epc;
      logic [63:0] pcn;
      logic [1:0]  cause;
      logic [2:0]  sel;
   } exp_t;

   logic        clk;
   logic        rst;

   // DUT a: MEM_LAT = 1
   logic        exc_opcode_a, exc_ovf_a;
   logic [63:0] pc_in_a, mem_data_a;
   logic        busy_a, epc_write_a, pc_write_a, done_a;
   logic [63:0] epc_out_a, pc_next_a;
   logic [2:0]  sel_a;
   logic [1:0]  cause_a;
   logic [7:0]  drop_a;

   // DUT b: MEM_LAT = 3
   logic        exc_opcode_b, exc_ovf_b;
   logic [63:0] pc_in_b, mem_data_b;
   logic        busy_b, epc_write_b, pc_write_b, done_b;
   logic [63:0] epc_out_b, pc_next_b;
   logic [2:0]  sel_b;
   logic [1:0]  cause_b;
   logic [7:0]  drop_b;

   logic [63:0] mem254_a, mem255_a, mem254_b, mem255_b;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_checks = 0;
   int n_fail   = 0;
   int run_a    = 0;
   int run_b    = 0;
   int exp_drop_a = 0;

   exception_sequencer #(.DATA_W(64), .MEM_LAT(1)) dut_a (
      .clk(clk), .rst(rst),
      .exc_opcode(exc_opcode_a), .exc_ovf(exc_ovf_a),
      .pc_in(pc_in_a), .mem_data(mem_data_a),
      .busy(busy_a), .epc_write(epc_write_a), .epc_out(epc_out_a),
      .sel_mux_excecao(sel_a), .pc_write(pc_write_a), .pc_next(pc_next_a),
      .done(done_a), .cause(cause_a), .drop_cnt(drop_a)
   );

   exception_sequencer #(.DATA_W(64), .MEM_LAT(3)) dut_b (
      .clk(clk), .rst(rst),
      .exc_opcode(exc_opcode_b), .exc_ovf(exc_ovf_b),
      .pc_in(pc_in_b), .mem_data(mem_data_b),
      .busy(busy_b), .epc_write(epc_write_b), .epc_out(epc_out_b),
      .sel_mux_excecao(sel_b), .pc_write(pc_write_b), .pc_next(pc_next_b),
      .done(done_b), .cause(cause_b), .drop_cnt(drop_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory behind the exception address mux (select 0 = AluOut path)
   always_comb begin
      mem_data_a = 64'h0BAD_0BAD_0BAD_0B11;
      if (sel_a == 3'd1) mem_data_a = mem254_a;
      else if (sel_a == 3'd2) mem_data_a = mem255_a;
      mem_data_b = 64'h0BAD_0BAD_0BAD_0B22;
      if (sel_b == 3'd1) mem_data_b = mem254_b;
      else if (sel_b == 3'd2) mem_data_b = mem255_b;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor, DUT a
   always @(negedge clk) begin
      if (!rst) run_a = 0;
      else begin
         if (busy_a) run_a++;
         else begin
            if (run_a != 0) check("a_busy_len", 64'(run_a), 64'd3);
            run_a = 0;
            check("a_idle_sel", 64'(sel_a), 64'd0);
         end
         if (epc_write_a) begin
            check("a_save_has_entry", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
               check("a_epc_out", epc_out_a, q_a[0].epc);
               check("a_save_sel", 64'(sel_a), 64'd0);
               check("a_save_busy", 64'(busy_a), 64'd1);
            end
         end else check("a_epc_zero", epc_out_a, 64'd0);
         if (done_a) begin
            check("a_done_has_entry", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
               check("a_pc_next", pc_next_a, q_a[0].pcn);
               check("a_pc_write", 64'(pc_write_a), 64'd1);
               check("a_cause", 64'(cause_a), 64'(q_a[0].cause));
               check("a_load_sel", 64'(sel_a), 64'(q_a[0].sel));
               void'(q_a.pop_front());
            end
         end else begin
            check("a_pc_next_zero", pc_next_a, 64'd0);
            check("a_pc_write_zero", 64'(pc_write_a), 64'd0);
         end
         if (busy_a && !epc_write_a && !done_a && q_a.size() != 0)
            check("a_addr_sel", 64'(sel_a), 64'(q_a[0].sel));
      end
   end

   // Scoreboard monitor, DUT b
   always @(negedge clk) begin
      if (!rst) run_b = 0;
      else begin
         if (busy_b) run_b++;
         else begin
            if (run_b != 0) check("b_busy_len", 64'(run_b), 64'd5);
            run_b = 0;
            check("b_idle_sel", 64'(sel_b), 64'd0);
         end
         if (epc_write_b) begin
            check("b_save_has_entry", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
               check("b_epc_out", epc_out_b, q_b[0].epc);
               check("b_save_sel", 64'(sel_b), 64'd0);
            end
         end else check("b_epc_zero", epc_out_b, 64'd0);
         if (done_b) begin
            check("b_done_has_entry", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
               check("b_pc_next", pc_next_b, q_b[0].pcn);
               check("b_pc_write", 64'(pc_write_b), 64'd1);
               check("b_cause", 64'(cause_b), 64'(q_b[0].cause));
               void'(q_b.pop_front());
            end
         end else check("b_pc_next_zero", pc_next_b, 64'd0);
         if (busy_b && !epc_write_b && !done_b && q_b.size() != 0)
            check("b_addr_sel", 64'(sel_b), 64'(q_b[0].sel));
      end
   end

   task automatic check_all_zero_a(input string tag);
      check({tag, "_busy"},  64'(busy_a), 64'd0);
      check({tag, "_epcw"},  64'(epc_write_a), 64'd0);
      check({tag, "_epc"},   epc_out_a, 64'd0);
      check({tag, "_sel"},   64'(sel_a), 64'd0);
      check({tag, "_pcw"},   64'(pc_write_a), 64'd0);
      check({tag, "_pcn"},   pc_next_a, 64'd0);
      check({tag, "_done"},  64'(done_a), 64'd0);
      check({tag, "_cause"}, 64'(cause_a), 64'd0);
      check({tag, "_drop"},  64'(drop_a), 64'd0);
   endtask

   // One accepted exception on DUT a: expectation pushed, flag pulsed one cycle
   task automatic seq_a(input logic [63:0] pc, input logic opc, input logic ovf,
                        input logic [63:0] epc, input logic [63:0] pcn, input logic [1:0] c);
      q_a.push_back('{epc: epc, pcn: pcn, cause: c, sel: {1'b0, c}});
      pc_in_a = pc; exc_opcode_a = opc; exc_ovf_a = ovf;
      @(negedge clk);
      exc_opcode_a = 1'b0; exc_ovf_a = 1'b0; pc_in_a = 64'hDEAD_BEEF_0000_0000;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      exc_opcode_a = 0; exc_ovf_a = 0; pc_in_a = 0;
      exc_opcode_b = 0; exc_ovf_b = 0; pc_in_b = 0;
      mem254_a = 64'h1234_5678_9ABC_DE80;
      mem255_a = 64'hFFFF_FFFF_FFFF_FF44;
      mem254_b = 64'h0000_0000_0000_0011;
      mem255_b = 64'hFFFF_FFFF_FFFF_FFA4;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero_a("rst_a");
      check("rst_b_busy", 64'(busy_b), 64'd0);
      check("rst_b_drop", 64'(drop_b), 64'd0);
      check("rst_b_pcn",  pc_next_b, 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Invalid opcode, MEM_LAT=1
      seq_a(64'h40, 1'b1, 1'b0, 64'h3C, 64'h80, 2'd1);
      check("opc_cause_sticky", 64'(cause_a), 64'd1);
      check("opc_drop", 64'(drop_a), 64'd0);

      // Overflow, MEM_LAT=3
      q_b.push_back('{epc: 64'hFC, pcn: 64'hA4, cause: 2'd2, sel: 3'd2});
      pc_in_b = 64'h100; exc_ovf_b = 1'b1;
      @(negedge clk);
      exc_ovf_b = 1'b0; pc_in_b = 64'h5555;
      repeat (8) @(negedge clk);
      check("ovf_cause_sticky", 64'(cause_b), 64'd2);
      check("ovf_drop", 64'(drop_b), 64'd0);

      // Simultaneous flags: opcode has priority, no drop
      seq_a(64'h200, 1'b1, 1'b1, 64'h1FC, 64'h80, 2'd1);
      check("simul_drop", 64'(drop_a), 64'(exp_drop_a));

      // EPC wrap-around
      seq_a(64'h0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h80, 2'd1);

      // Held overflow flag: 3 drops, then restart at first IDLE edge
      q_a.push_back('{epc: 64'h2FC, pcn: 64'h44, cause: 2'd2, sel: 3'd2});
      q_a.push_back('{epc: 64'h2FC, pcn: 64'h44, cause: 2'd2, sel: 3'd2});
      pc_in_a = 64'h300; exc_ovf_a = 1'b1;
      repeat (5) @(negedge clk);
      exc_ovf_a = 1'b0;
      repeat (6) @(negedge clk);
      exp_drop_a += 3;
      check("hold_drop", 64'(drop_a), 64'(exp_drop_a));
      check("hold_queue_empty", 64'(q_a.size()), 64'd0);

      // Reset in the middle of ADDR
      q_a.push_back('{epc: 64'h4FC, pcn: 64'h80, cause: 2'd1, sel: 3'd1});
      pc_in_a = 64'h500; exc_opcode_a = 1'b1;
      @(negedge clk);
      exc_opcode_a = 1'b0;
      @(negedge clk);
      check("pre_rst_addr_sel", 64'(sel_a), 64'd1);
      rst = 1'b0;
      #1;
      check_all_zero_a("abort");
      q_a.delete();
      exp_drop_a = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_rst_busy", 64'(busy_a), 64'd0);
      end
      check("post_rst_cause", 64'(cause_a), 64'd0);

      // Drop counter saturation: 100 sequences x 3 dropped edges = 300
      pc_in_a = 64'h600; exc_ovf_a = 1'b1;
      for (int i = 0; i < 100; i++) begin
         q_a.push_back('{epc: 64'h5FC, pcn: 64'h44, cause: 2'd2, sel: 3'd2});
         repeat (4) @(negedge clk);
      end
      exc_ovf_a = 1'b0;
      repeat (6) @(negedge clk);
      check("sat_drop", 64'(drop_a), 64'd255);
      check("sat_queue_empty", 64'(q_a.size()), 64'd0);
      check("final_b_queue_empty", 64'(q_b.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
Multicycle exception sequencer for the 64-bit RISC-V datapath. It sits beside the main control unit. On an invalid-opcode or arithmetic-overflow event it stalls the control unit, saves the faulting PC into EPC, and reads the handler address from the data memory vector slot (254 or 255) through the exception address mux. It then loads that handler address into PC.

Parameters:
DATA_W, 64, datapath/PC width
VEC_OPCODE, 254, data-memory vector address for invalid opcode (mux select 1)
VEC_OVF, 255, data-memory vector address for overflow (mux select 2)
MEM_LAT, 1, data-memory read latency in cycles (legal 1..7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
exc_opcode  in  1  invalid-opcode flag from control unit, level, sampled only in IDLE
exc_ovf  in  1  ALU overflow flag, level, sampled only in IDLE
pc_in  in  DATA_W  current PC register value (already advanced by 4)
mem_data  in  DATA_W  data-memory read data
busy  out  1  high while sequence active; control unit must freeze its own FSM and all its write enables
epc_write  out  1  EPC register load enable
epc_out  out  DATA_W  value to load into EPC
sel_mux_excecao  out  3  exception address mux select: 0 = AluOut, 1 = VEC_OPCODE, 2 = VEC_OVF
pc_write  out  1  PC load enable, overrides control unit while busy
pc_next  out  DATA_W  handler address driven to PC
done  out  1  one-cycle pulse on the handler load cycle
cause  out  2  sticky last cause: 0 none, 1 opcode, 2 overflow
drop_cnt  out  8  saturating count of exceptions ignored while busy

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, lat counter=0.
  - pc capture register=0, vector-select register=0.
  - All outputs 0: busy, epc_write, epc_out, sel_mux_excecao, pc_write, pc_next, done, cause, drop_cnt.
  - Reset mid-sequence aborts with no further writes.
- FSM states: IDLE, SAVE, ADDR, LOAD. Outputs decode from state registers only (Moore).
- IDLE:
  - busy=0, all enables 0, sel=0.
  - At a rising edge with exc_opcode|exc_ovf=1:
    - capture pc_in.
    - Select cause: exc_opcode has priority if both are high; opcode -> vsel=1, ovf -> vsel=2.
    - cause <= vsel.
    - Go to SAVE.
- SAVE, 1 cycle:
  - busy=1, epc_write=1, epc_out = captured_pc - 4, modulo 2^DATA_W (0 -> 0xFFFF_FFFF_FFFF_FFFC), sel=0.
  - Load lat counter=MEM_LAT; go to ADDR.
- ADDR, MEM_LAT cycles:
  - busy=1, sel=vsel, no writes.
  - Counter decrements each cycle; at count 1 go to LOAD.
- LOAD, 1 cycle:
  - busy=1, sel=vsel still held.
  - pc_write=1, pc_next = zero-extended mem_data[7:0], done=1.
  - Go to IDLE.
- Latency: flag sampled at edge N -> epc_write during cycle N+1 -> pc_write/done during cycle N+2+MEM_LAT -> busy=0 from cycle N+3+MEM_LAT.
- Back-to-back: a flag still high in the first IDLE cycle starts a new sequence at that edge. The control unit must clear its flag on done. The minimum IDLE dwell is 1 cycle.
- Flags high while busy (SAVE/ADDR/LOAD) are not queued.
  - On each such edge (either or both flags), drop_cnt increments by 1 and saturates at 255.
  - drop_cnt clears only on reset.
- cause holds its value until the next accepted exception or reset. It is not cleared on done.
- pc_in and mem_data changes outside the capture edge and the LOAD cycle have no effect.
- epc_out is driven only in SAVE; it is 0 in the other states.
- pc_next is driven only in LOAD; it is 0 in the other states.

Test Plan:
- Reset check: rst=0 mid-ADDR -> next cycle all outputs 0, state IDLE; after release with no flags, busy stays 0 for 10 cycles.
- Invalid opcode, MEM_LAT=1: pc_in=0x0000_0000_0000_0040, exc_opcode pulse, mem[254] byte=0x80 ->
  - SAVE: epc_write=1, epc_out=0x3C.
  - ADDR: sel=1 for 1 cycle.
  - LOAD: pc_write=1, pc_next=0x80, done=1, cause=1.
  - busy high for exactly 3 cycles.
- Overflow, MEM_LAT=3: pc_in=0x100, exc_ovf=1, mem[255]=0xFFFF_FFFF_FFFF_FFA4 ->
  - epc_out=0xFC, sel=2 for 3 cycles.
  - pc_next=0xA4 (upper bits discarded), cause=2, busy high 5 cycles.
- Simultaneous flags: exc_opcode=exc_ovf=1 at the same edge -> cause=1, sel=1, drop_cnt unchanged.
- Drops and saturation:
  - Hold exc_ovf high through a MEM_LAT=1 sequence -> drop_cnt increments by 3 (SAVE, ADDR, LOAD edges); a new sequence starts at the first IDLE edge.
  - 300 busy-cycle flags -> drop_cnt=255.
- EPC wrap: pc_in=0, exc_opcode=1 -> epc_out=0xFFFF_FFFF_FFFF_FFFC.
